// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int UART_DATA_W = 8;
    localparam int MAX_REQ     = 4;
    localparam int GRANT_W     = 2;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// returned both one-hot and as an index.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]       valid,
    input  logic [GRANT_W-1:0] ptr,
    output logic [N-1:0]       grant,
    output logic [GRANT_W-1:0] idx
);

    logic [N-1:0] rot;

    // Rotate so bit 0 is the requester sitting at the pointer.
    assign rot = N'({valid, valid} >> ptr);

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx   = GRANT_W'((int'(ptr) + k) % N);
                grant = N'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional macro UART_ARB_LOCK_EN adds req_lock to keep multi-byte messages contiguous.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             req_lock,
`endif
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_DATA_W-1:0]         tx_data,
    output logic                           tx_start,
    input  logic                           tx_busy,
    output logic [GRANT_W-1:0]             grant_id,
    output logic                           active,
    output logic                           timeout_err
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    state_t               state, state_nxt;
    logic [GRANT_W-1:0]   rr_ptr, ptr_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [GRANT_W-1:0]   pick_idx;
    logic                 accept, done, timeout_hit, lock_hold;

    rr_picker #(.N(NUM_REQ)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

`ifdef UART_ARB_LOCK_EN
    assign lock_hold = |(req_lock & (NUM_REQ'(1) << grant_id));
`else
    assign lock_hold = 1'b0;
`endif

    assign ptr_nxt = lock_hold ? grant_id :
                     (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);
    assign active  = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        tx_start    = 1'b0;
        accept      = 1'b0;
        done        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_busy && |req_valid) begin
                    accept    = 1'b1;
                    req_ready = pick_oh;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start  = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    // UART never acknowledged the start: drop the byte.
                    timeout_hit = 1'b1;
                    done        = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            tx_data     <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                tx_data  <= UART_DATA_W'(req_data >> {pick_idx, 3'b000});
                grant_id <= pick_idx;
            end
            if (state == LAUNCH)
                cnt <= '0;
            else if (state == WAIT_BUSY && !tx_busy && cnt != CNT_LAST)
                cnt <= cnt + CNT_W'(1);
            if (timeout_hit)
                timeout_err <= 1'b1;
            if (done)
                rr_ptr <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=2, BUSY_TIMEOUT=64); lock test runs when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;
`ifdef UART_ARB_LOCK_EN
    logic [1:0]  req_lock;
`endif

    logic        uart_auto = 1'b0;
    logic        man_busy  = 1'b0;
    int          mdl_cnt   = 0;
    int          compared  = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    // Simple UART: busy for 5 cycles after each start strobe, survives DUT reset.
    always @(posedge clk) begin
        if (tx_start)
            mdl_cnt <= 5;
        else if (mdl_cnt > 0)
            mdl_cnt <= mdl_cnt - 1;
    end
    assign tx_busy = uart_auto ? (mdl_cnt != 0) : man_busy;

    uart_tx_arbiter #(.NUM_REQ(2), .BUSY_TIMEOUT(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while ((active || tx_busy) && c < 100) begin
            step();
            c++;
        end
        chk(tag, {31'd0, active}, 32'd0);
    endtask

    initial begin
        logic [7:0] got [4];
        logic [1:0] prev;
        int         n, ov;

`ifdef UART_ARB_LOCK_EN
        req_lock = 2'b00;
`endif
        rst_n = 1'b0; req_valid = 2'b00; req_data = 16'h0000;
        #3;
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_start", {31'd0, tx_start}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
        step();
        rst_n = 1'b1;

        // Test 1: single byte, same-cycle ready, start one cycle later.
        req_valid = 2'b01; req_data = 16'h0058;
        #1;
        chk("t1_ready", {30'd0, req_ready}, 32'h1);
        step();
        req_valid = 2'b00;
        chk("t1_start", {31'd0, tx_start}, 32'd1);
        chk("t1_data", {24'd0, tx_data}, 32'h58);
        chk("t1_ready_gone", {30'd0, req_ready}, 32'd0);
        man_busy = 1'b1;
        step();
        chk("t1_start_1cyc", {31'd0, tx_start}, 32'd0);
        repeat (9) step();
        chk("t1_active_busy", {31'd0, active}, 32'd1);
        man_busy = 1'b0;
        #1;
        chk("t1_active_hold", {31'd0, active}, 32'd1);
        step();
        chk("t1_active_drop", {31'd0, active}, 32'd0);

        // Test 2: both requesters continuously valid, grants alternate.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        uart_auto = 1'b1;
        req_valid = 2'b11; req_data = 16'h4241;
        #1;
        chk("t2_first_ready", {30'd0, req_ready}, 32'h1);
        prev = req_ready; n = 0; ov = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            step();
            if (req_ready != 2'b00 && prev != 2'b00) ov++;
            if (req_ready == 2'b11) ov++;
            prev = req_ready;
            if (tx_start) begin
                got[n] = tx_data;
                n++;
            end
        end
        chk("t2_count", n, 4);
        chk("t2_b0", {24'd0, got[0]}, 32'h41);
        chk("t2_b1", {24'd0, got[1]}, 32'h42);
        chk("t2_b2", {24'd0, got[2]}, 32'h41);
        chk("t2_b3", {24'd0, got[3]}, 32'h42);
        chk("t2_ready_pulse", ov, 0);
        req_valid = 2'b00;
        wait_idle("t2_idle");

        // Test 3: UART busy in IDLE blocks accepts.
        uart_auto = 1'b0; man_busy = 1'b1;
        req_valid = 2'b10; req_data = 16'h7700;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t3_no_ready", {30'd0, req_ready}, 32'd0);
            chk("t3_no_start", {31'd0, tx_start}, 32'd0);
        end
        man_busy = 1'b0;
        #1;
        chk("t3_ready", {30'd0, req_ready}, 32'h2);
        step();
        req_valid = 2'b00;
        chk("t3_start", {31'd0, tx_start}, 32'd1);
        chk("t3_data", {24'd0, tx_data}, 32'h77);
        chk("t3_grant", {30'd0, grant_id}, 32'd1);

        // Test 4: busy never rises, timeout after 64 cycles in WAIT_BUSY.
        repeat (64) step();
        chk("t4_tmo_early", {31'd0, timeout_err}, 32'd0);
        chk("t4_active_early", {31'd0, active}, 32'd1);
        step();
        chk("t4_tmo", {31'd0, timeout_err}, 32'd1);
        chk("t4_active", {31'd0, active}, 32'd0);
        req_valid = 2'b11; req_data = 16'h4241;
        #1;
        chk("t4_next_grant", {30'd0, req_ready}, 32'h1);
        step();
        req_valid = 2'b00;
        uart_auto = 1'b1;
        chk("t4_next_data", {24'd0, tx_data}, 32'h41);
        wait_idle("t4_idle");
        chk("t4_tmo_sticky", {31'd0, timeout_err}, 32'd1);

        // Test 5: async reset during WAIT_DONE.
        req_valid = 2'b11;
        #1;
        chk("t5_ready", {30'd0, req_ready}, 32'h2);
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("t5_pre_active", {31'd0, active}, 32'd1);
        chk("t5_pre_grant", {30'd0, grant_id}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_start", {31'd0, tx_start}, 32'd0);
        chk("t5_active", {31'd0, active}, 32'd0);
        chk("t5_grant", {30'd0, grant_id}, 32'd0);
        chk("t5_tmo", {31'd0, timeout_err}, 32'd0);
        chk("t5_data", {24'd0, tx_data}, 32'd0);
        rst_n = 1'b1;
        req_valid = 2'b01;
        #1;
        chk("t5_busy_blocks", {30'd0, req_ready}, 32'd0);
        n = 0;
        for (int c = 0; c < 50 && n == 0; c++) begin
            step();
            if (tx_start) n = 1;
        end
        chk("t5_resume", n, 1);
        chk("t5_resume_data", {24'd0, tx_data}, 32'h41);
        req_valid = 2'b00;
        wait_idle("t5_idle");

`ifdef UART_ARB_LOCK_EN
        // Test 6: requester 0 locks for three bytes.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req_lock = 2'b01; req_valid = 2'b11;
        n = 0;
        for (int c = 0; c < 300 && n < 4; c++) begin
            step();
            if (tx_start) begin
                got[n] = {6'd0, grant_id};
                n++;
                if (n == 3) req_lock = 2'b00;
            end
        end
        chk("t6_count", n, 4);
        chk("t6_g0", {24'd0, got[0]}, 32'd0);
        chk("t6_g1", {24'd0, got[1]}, 32'd0);
        chk("t6_g2", {24'd0, got[2]}, 32'd0);
        chk("t6_g3", {24'd0, got[3]}, 32'd1);
        req_valid = 2'b00;
        wait_idle("t6_idle");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
